// File: rtl/taxi_eth_phy_10g_pkg.sv
// Shared types and constants for the 10GBASE-R receive path.
package taxi_eth_phy_10g_pkg;

    typedef enum logic [2:0] {
        SERDES_RST,
        SERDES_WAIT,
        HUNT,
        LOCKED,
        RESYNC
    } rx_sync_state_e;

    localparam logic [1:0] SYNC_DATA = 2'b10;
    localparam logic [1:0] SYNC_CTRL = 2'b01;

    function automatic logic hdr_is_valid(input logic [1:0] hdr);
        return (hdr == SYNC_DATA) || (hdr == SYNC_CTRL);
    endfunction

endpackage

// File: rtl/taxi_eth_phy_10g_rx_ber_mon.sv
// Clause 49 BER monitor: 125 us window, saturating invalid-header count, hi_ber flag.
module taxi_eth_phy_10g_rx_ber_mon #(
    parameter int COUNT_125US = 19531,
    parameter int BER_THRESH  = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic bad_hdr_i,
    output logic win_end_o,
    output logic win_hi_o,
    output logic hi_ber_o
);

    localparam int WIN_W = $clog2(COUNT_125US);
    localparam int CNT_W = $clog2(BER_THRESH + 1);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(COUNT_125US - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(BER_THRESH);

    logic [WIN_W-1:0] win_q, win_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hi_ber_q, hi_ber_d;

    assign win_end_o = (win_q == WIN_LAST);
    assign win_hi_o  = (cnt_q == CNT_SAT);
    assign hi_ber_o  = hi_ber_q;

    always_comb begin
        win_d    = win_q + 1'b1;
        cnt_d    = cnt_q;
        hi_ber_d = hi_ber_q;
        if (!en_i) begin
            win_d    = '0;
            cnt_d    = '0;
            hi_ber_d = 1'b0;
        end else begin
            // A bad header on the window-end cycle opens the next window's count.
            if (win_end_o) begin
                win_d    = '0;
                cnt_d    = CNT_W'(bad_hdr_i);
                hi_ber_d = win_hi_o;
            end else if (bad_hdr_i && !win_hi_o) begin
                cnt_d = cnt_q + 1'b1;
            end
            if (cnt_d == CNT_SAT) begin
                hi_ber_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q    <= '0;
            cnt_q    <= '0;
            hi_ber_q <= 1'b0;
        end else begin
            win_q    <= win_d;
            cnt_q    <= cnt_d;
            hi_ber_q <= hi_ber_d;
        end
    end

endmodule

// File: rtl/taxi_eth_phy_10g_rx_sync_ctrl.sv
// Sequences SERDES RX reset, frame-sync reset and block-lock hunting, and
// forces resync or SERDES reset on lock timeout or persistent hi_ber.
module taxi_eth_phy_10g_rx_sync_ctrl #(
    parameter int HDR_W             = 2,
    parameter int COUNT_125US       = 19531,
    parameter int BER_THRESH        = 16,
    parameter int LOCK_TIMEOUT      = 125000,
    parameter int SERDES_RST_CYCLES = 64,
    parameter int HI_BER_RESYNC_WIN = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [HDR_W-1:0] serdes_rx_hdr_i,
    input  logic             serdes_rx_hdr_valid_i,
    input  logic             serdes_rx_reset_done_i,
    input  logic             rx_block_lock_i,
    output logic             serdes_rx_reset_o,
    output logic             frame_sync_rst_o,
    output logic             rx_high_ber_o,
    output logic             rx_status_o,
    output logic [15:0]      rx_err_count_o,
    output logic [7:0]       rx_relock_count_o
);

    import taxi_eth_phy_10g_pkg::*;

    generate
        if (HDR_W != 2) begin : g_hdr_w_check
            $fatal(1, "HDR_W must be 2");
        end
    endgenerate

    localparam int TMR_MAX = (LOCK_TIMEOUT > SERDES_RST_CYCLES) ? LOCK_TIMEOUT : SERDES_RST_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int RUN_W   = $clog2(HI_BER_RESYNC_WIN + 1);
    localparam logic [TMR_W-1:0] RST_LAST = TMR_W'(SERDES_RST_CYCLES - 1);
    localparam logic [TMR_W-1:0] TO_LAST  = TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(HI_BER_RESYNC_WIN - 1);

    rx_sync_state_e   state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic             hunt_seen_q;
    logic             serdes_rx_reset_q;
    logic             frame_sync_rst_q;
    logic             rx_status_q;
    logic [15:0]      err_q;
    logic [7:0]       relock_q;
    logic             bad_hdr, ber_en, win_end, win_hi, hi_ber, resync;

    assign bad_hdr = serdes_rx_hdr_valid_i && !hdr_is_valid(serdes_rx_hdr_i);
    assign resync  = (state_q == LOCKED) && win_end && win_hi && (run_q == RUN_LAST);
    // Monitor runs only while LOCKED persists; it is cleared on the edge that leaves.
    assign ber_en  = (state_q == LOCKED) && (state_d == LOCKED);

    always_comb begin
        state_d = state_q;
        case (state_q)
            SERDES_RST: begin
                if (tmr_q == RST_LAST) state_d = SERDES_WAIT;
            end
            SERDES_WAIT: begin
                if (serdes_rx_reset_done_i) state_d = HUNT;
                else if (tmr_q == TO_LAST)  state_d = SERDES_RST;
            end
            HUNT: begin
                if (!serdes_rx_reset_done_i) state_d = SERDES_RST;
                else if (rx_block_lock_i)    state_d = LOCKED;
                else if (tmr_q == TO_LAST)   state_d = SERDES_RST;
            end
            LOCKED: begin
                if (!serdes_rx_reset_done_i) state_d = SERDES_RST;
                else if (!rx_block_lock_i)   state_d = HUNT;
                else if (resync)             state_d = RESYNC;
            end
            RESYNC:  state_d = HUNT;
            default: state_d = SERDES_RST;
        endcase
    end

    always_comb begin
        tmr_d = tmr_q + 1'b1;
        if ((state_d != state_q) || (state_q == LOCKED)) begin
            tmr_d = '0;
        end
        run_d = run_q;
        if (!ber_en) begin
            run_d = '0;
        end else if (win_end) begin
            run_d = win_hi ? run_q + 1'b1 : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= SERDES_RST;
            tmr_q             <= '0;
            run_q             <= '0;
            hunt_seen_q       <= 1'b0;
            serdes_rx_reset_q <= 1'b1;
            frame_sync_rst_q  <= 1'b1;
            rx_status_q       <= 1'b0;
            err_q             <= '0;
            relock_q          <= '0;
        end else begin
            state_q           <= state_d;
            tmr_q             <= tmr_d;
            run_q             <= run_d;
            serdes_rx_reset_q <= (state_d == SERDES_RST);
            frame_sync_rst_q  <= (state_d == SERDES_RST) || (state_d == SERDES_WAIT) ||
                                 (state_d == RESYNC);
            rx_status_q       <= ber_en && !hi_ber;
            if ((state_q == LOCKED) && bad_hdr && (err_q != 16'hFFFF)) begin
                err_q <= err_q + 16'd1;
            end
            if ((state_d == HUNT) && (state_q != HUNT)) begin
                hunt_seen_q <= 1'b1;
                if (hunt_seen_q && (relock_q != 8'hFF)) begin
                    relock_q <= relock_q + 8'd1;
                end
            end
        end
    end

    taxi_eth_phy_10g_rx_ber_mon #(
        .COUNT_125US (COUNT_125US),
        .BER_THRESH  (BER_THRESH)
    ) u_ber_mon (
        .clk       (clk),
        .rst_n     (rst_n),
        .en_i      (ber_en),
        .bad_hdr_i (bad_hdr),
        .win_end_o (win_end),
        .win_hi_o  (win_hi),
        .hi_ber_o  (hi_ber)
    );

    assign serdes_rx_reset_o = serdes_rx_reset_q;
    assign frame_sync_rst_o  = frame_sync_rst_q;
    assign rx_high_ber_o     = hi_ber;
    assign rx_status_o       = rx_status_q;
    assign rx_err_count_o    = err_q;
    assign rx_relock_count_o = relock_q;

endmodule

// File: tb/tb_taxi_eth_phy_10g_rx_sync_ctrl.sv
// Bench for the RX sync controller: startup table, hand-written corner cases,
// and randomized traffic checked every cycle against a behavioural model.
module tb_taxi_eth_phy_10g_rx_sync_ctrl;

    localparam int CNT  = 100;
    localparam int TO   = 500;
    localparam int RSTC = 4;
    localparam int THR  = 16;
    localparam int WIN  = 2;
    localparam logic [27:0] RST_PACK = {1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 8'h0};

    localparam int M_RST = 0, M_WAIT = 1, M_HUNT = 2, M_LOCK = 3, M_RESYNC = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [1:0]  hdr = 2'b10;
    logic        hv = 1'b0, done = 1'b0, lock = 1'b0;
    logic        srst, fsr, hiber, status;
    logic [15:0] errc;
    logic [7:0]  relock;

    always #5 clk = ~clk;

    taxi_eth_phy_10g_rx_sync_ctrl #(
        .HDR_W             (2),
        .COUNT_125US       (CNT),
        .BER_THRESH        (THR),
        .LOCK_TIMEOUT      (TO),
        .SERDES_RST_CYCLES (RSTC),
        .HI_BER_RESYNC_WIN (WIN)
    ) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .serdes_rx_hdr_i        (hdr),
        .serdes_rx_hdr_valid_i  (hv),
        .serdes_rx_reset_done_i (done),
        .rx_block_lock_i        (lock),
        .serdes_rx_reset_o      (srst),
        .frame_sync_rst_o       (fsr),
        .rx_high_ber_o          (hiber),
        .rx_status_o            (status),
        .rx_err_count_o         (errc),
        .rx_relock_count_o      (relock)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Behavioural model: state plus time-in-state; window position is derived
    // arithmetically from the time spent in LOCKED.
    int m_st, m_age, m_wbad, m_run, m_err, m_relock, m_hunts;
    bit m_hi, m_status;

    task automatic chk(input string name, input logic [27:0] act, input logic [27:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%07h expected 0x%07h", name, act, exp);
    endtask

    function automatic logic [27:0] dut_pack();
        return {srst, fsr, hiber, status, errc, relock};
    endfunction

    function automatic logic [27:0] model_pack();
        logic ms, mf;
        ms = (m_st == M_RST);
        mf = (m_st == M_RST) || (m_st == M_WAIT) || (m_st == M_RESYNC);
        return {ms, mf, m_hi, m_status, m_err[15:0], m_relock[7:0]};
    endfunction

    task automatic model_reset();
        m_st = M_RST; m_age = 0; m_wbad = 0; m_run = 0;
        m_err = 0; m_relock = 0; m_hunts = 0; m_hi = 0; m_status = 0;
    endtask

    task automatic model_step(input bit d, input bit l, input bit bad);
        int  nst;
        bit  wend, whi;
        nst  = m_st;
        wend = (m_st == M_LOCK) && ((m_age % CNT) == CNT - 1);
        whi  = wend && (m_wbad >= THR);
        case (m_st)
            M_RST:  if (m_age == RSTC - 1) nst = M_WAIT;
            M_WAIT: if (d) nst = M_HUNT; else if (m_age == TO - 1) nst = M_RST;
            M_HUNT: if (!d) nst = M_RST; else if (l) nst = M_LOCK;
                    else if (m_age == TO - 1) nst = M_RST;
            M_LOCK: if (!d) nst = M_RST; else if (!l) nst = M_HUNT;
                    else if (whi && (m_run + 1 >= WIN)) nst = M_RESYNC;
            default: nst = M_HUNT;
        endcase
        m_status = (m_st == M_LOCK) && (nst == M_LOCK) && !m_hi;
        if ((m_st == M_LOCK) && bad && (m_err < 65535)) m_err++;
        if ((nst == M_HUNT) && (m_st != M_HUNT)) begin
            if ((m_hunts > 0) && (m_relock < 255)) m_relock++;
            m_hunts++;
        end
        if ((m_st == M_LOCK) && (nst == M_LOCK)) begin
            if (wend) begin
                m_run  = whi ? m_run + 1 : 0;
                m_hi   = whi;
                m_wbad = bad ? 1 : 0;
            end else begin
                m_wbad += bad ? 1 : 0;
            end
            if (m_wbad >= THR) m_hi = 1;
        end else begin
            m_run = 0; m_hi = 0; m_wbad = 0;
        end
        m_age = (nst == m_st) ? m_age + 1 : 0;
        m_st  = nst;
    endtask

    task automatic step(input logic d, input logic l, input logic v, input logic [1:0] h);
        bit bad;
        done = d; lock = l; hv = v; hdr = h;
        bad = v && !((h == 2'b01) || (h == 2'b10));
        model_step(d, l, bad);
        @(posedge clk);
        #1;
        cyc++;
        chk($sformatf("cycle %0d outputs vs model", cyc), dut_pack(), model_pack());
    endtask

    task automatic do_reset();
        rst_n = 1'b0; done = 1'b0; lock = 1'b0; hv = 1'b0; hdr = 2'b10;
        #1;
        chk("async reset values", dut_pack(), RST_PACK);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc = 0;
    endtask

    typedef struct {
        int         cyc;
        logic       d;
        logic       l;
        logic       srst;
        logic       fsr;
        logic       st;
        logic [7:0] relock;
    } vec_t;

    vec_t tbl[9];

    initial begin
        int r;
        int hi_seen;
        tbl[0] = '{0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0};
        tbl[1] = '{3,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0};
        tbl[2] = '{4,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0};
        tbl[3] = '{10, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0};
        tbl[4] = '{11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[5] = '{30, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[6] = '{31, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[7] = '{32, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0};
        tbl[8] = '{33, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0};

        #3;
        // Startup sequence from the table
        do_reset();
        r = 0;
        while (cyc <= 33) begin
            while ((r < 8) && (tbl[r+1].cyc <= cyc)) r++;
            if (tbl[r].cyc == cyc)
                chk($sformatf("startup c%0d {srst,fsr,status,relock}", cyc),
                    28'({srst, fsr, status, relock}),
                    28'({tbl[r].srst, tbl[r].fsr, tbl[r].st, tbl[r].relock}));
            step(tbl[r].d, tbl[r].l, 1'b1, 2'b10);
        end

        // Lock timeout: HUNT from cycle 5, SERDES reset again at 505
        do_reset();
        while (cyc <= 1012) begin
            if (cyc == 504)  chk("timeout srst@504", 28'(srst), 28'd0);
            if (cyc == 505)  chk("timeout srst@505", 28'(srst), 28'd1);
            if (cyc == 508)  chk("timeout srst@508", 28'(srst), 28'd1);
            if (cyc == 509)  chk("timeout {srst,fsr}@509", 28'({srst, fsr}), 28'b01);
            if (cyc == 510)  chk("timeout fsr@510", 28'(fsr), 28'd0);
            if (cyc == 1010) chk("timeout srst@1010", 28'(srst), 28'd1);
            step(1'b1, 1'b0, 1'b1, 2'b10);
        end

        // hi_ber: 16 bad headers at cycles 10..25, LOCKED since cycle 6
        do_reset();
        while (cyc <= 208) begin
            if (cyc == 25)  chk("hiber@25", 28'(hiber), 28'd0);
            if (cyc == 26)  chk("hiber@26", 28'(hiber), 28'd1);
            if (cyc == 27)  chk("status@27", 28'(status), 28'd0);
            if (cyc == 205) chk("hiber@205", 28'(hiber), 28'd1);
            if (cyc == 206) chk("hiber@206", 28'(hiber), 28'd0);
            if (cyc == 207) chk("status@207", 28'(status), 28'd1);
            step(1'b1, 1'b1, 1'b1, ((cyc >= 10) && (cyc <= 25)) ? 2'b00 : 2'b01);
        end
        chk("hiber err_count", 28'(errc), 28'd16);

        // Below threshold: 15 bad headers in each of 3 windows
        do_reset();
        hi_seen = 0;
        while (cyc <= 306) begin
            if (hiber) hi_seen++;
            step(1'b1, 1'b1, 1'b1,
                 ((cyc >= 6) && (cyc < 306) && ((cyc - 6) % CNT >= 10) && ((cyc - 6) % CNT <= 24))
                 ? 2'b11 : 2'b10);
        end
        chk("below-threshold hiber cycles", 28'(hi_seen), 28'd0);
        chk("below-threshold err_count", 28'(errc), 28'd45);

        // Forced resync: 20 bad headers in windows 0 and 1
        do_reset();
        while (cyc <= 221) begin
            if (cyc == 205) chk("resync fsr@205", 28'(fsr), 28'd0);
            if (cyc == 206) chk("resync {fsr,hiber}@206", 28'({fsr, hiber}), 28'b10);
            if (cyc == 207) chk("resync {fsr,relock}@207", 28'({fsr, relock}), 28'({1'b0, 8'd1}));
            step(1'b1, (cyc != 220), 1'b1,
                 ((cyc >= 6) && (cyc < 206) && ((cyc - 6) % CNT >= 10) && ((cyc - 6) % CNT <= 29))
                 ? 2'b00 : 2'b10);
        end
        // Lock dropped at cycle 220 -> HUNT at 221
        chk("lock drop relock@221", 28'(relock), 28'd2);
        while (cyc <= 230) step(1'b1, 1'b1, 1'b1, 2'b01);
        chk("relocked status@231", 28'(status), 28'd1);
        #2;
        do_reset();

        // Randomized traffic
        for (int ch = 0; ch < 12; ch++) begin
            int   rate;
            logic dmode, lmode;
            case ($urandom_range(0, 3))
                0:       rate = 0;
                1:       rate = 10;
                2:       rate = 20;
                default: rate = 40;
            endcase
            dmode = ($urandom_range(0, 7) != 0);
            lmode = ($urandom_range(0, 5) != 0);
            for (int k = 0; k < 400; k++) begin
                logic       d, l, v;
                logic [1:0] h;
                d = dmode && ($urandom_range(0, 499) != 0);
                l = lmode && ($urandom_range(0, 299) != 0);
                v = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 99) < rate) h = $urandom_range(0, 1) ? 2'b00 : 2'b11;
                else                              h = $urandom_range(0, 1) ? 2'b01 : 2'b10;
                step(d, l, v, h);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
